uart_tx: RTL
============

Name: uart_tx

Overview:
Byte serializer that drives the UART TXD pin from the byte/enable pair produced by the UART application logic.
- Each rising edge on uart_tx_enable queues one byte into a small FIFO.
- The FIFO drains as 8N1 frames at BAUD_RATE, LSB first.
- Tolerates multi-cycle enable pulses: the timer PPS pulse is 10 cycles wide and produces exactly one byte.

Parameters:
- CLK_FREQ, 32'd50_000_000: input clock frequency in Hz.
- BAUD_RATE, 32'd115_200: line rate in bit/s. BAUD_DIV = CLK_FREQ / BAUD_RATE (integer truncation); 434 at the defaults. BAUD_DIV must be >= 2.
- FIFO_DEPTH_LOG2, 2: FIFO depth = 2**FIFO_DEPTH_LOG2 bytes (4 by default).

Ports:
- clk_50m  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- uart_tx_data  input  8  byte to send; must be stable in the cycle after uart_tx_enable rises.
- uart_tx_enable  input  1  level/pulse request; only the rising edge is significant.
- uart_txd  output  1  serial line, idle high.
- tx_busy  output  1  high while a frame is in flight or the FIFO is non-empty.
- tx_fifo_full  output  1  FIFO holds DEPTH bytes.
- tx_overflow  output  1  sticky: a request was dropped.

Behaviour:
- One clock: clk_50m. Reset is asynchronous and active-high.
- Reset values: uart_txd=1, tx_busy=0, tx_fifo_full=0, tx_overflow=0, FIFO empty, FSM=IDLE, all counters 0.
- Edge detect:
  - uart_tx_enable is registered into en_d1, then en_d2.
  - push = en_d1 & ~en_d2, i.e. one cycle after enable is first seen high.
  - In the push cycle, uart_tx_data is written to the FIFO.
  - Enable held high for any length produces one push only.
- FIFO:
  - Push is accepted if count < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the byte is dropped and tx_overflow is set; it stays 1 until reset.
  - Read/write pointers are FIFO_DEPTH_LOG2 bits wide and wrap naturally. Count is FIFO_DEPTH_LOG2+1 bits.
  - Simultaneous push and pop leaves count unchanged.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see below).
  - IDLE: uart_txd=1. If the FIFO is non-empty, pop into shift register, clear baud_cnt and bit_cnt, go to START.
  - START: uart_txd=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: uart_txd=shift[0]. Every BAUD_DIV cycles, shift right and increment bit_cnt (3 bits). After the 8th bit, go to STOP.
  - STOP: uart_txd=1 for BAUD_DIV cycles, then go to IDLE.
- Baud counter: counts 0..BAUD_DIV-1 within each bit and wraps to 0 on a bit boundary. It is reset on every frame start.
- Timing:
  - uart_txd is registered.
  - Push in cycle N into an empty FIFO with the FSM idle: pop in N+1, uart_txd low from N+2.
  - Frame length is 10*BAUD_DIV cycles.
  - Back-to-back frames are separated by exactly 1 IDLE cycle.
- tx_busy = (state != IDLE) | (count != 0), registered.
- tx_fifo_full = (count == DEPTH), registered.
- Reset mid-frame: uart_txd goes to 1 asynchronously. The in-flight byte and FIFO contents are discarded.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - uart_txd = ^byte (even parity) for BAUD_DIV cycles.
  - Frame length is 11*BAUD_DIV cycles.
- When undefined: no PARITY state or logic, and the frame is pure 8N1.

Test Plan:
- Use BAUD_RATE=5_000_000 in all scenarios, giving BAUD_DIV=10.
- Assert reset for 5 cycles, release -> uart_txd=1, tx_busy=0, tx_fifo_full=0, tx_overflow=0; no activity for 200 cycles.
- Data 0xA5 with a 10-cycle enable pulse -> uart_txd low 2 cycles after push, then bits 1,0,1,0,0,1,0,1 and stop=1, each exactly 10 cycles (100 total); tx_busy drops after the stop bit.
- Enable held high for 500 cycles with data 0x3C -> exactly one 0x3C frame.
- Six 10-cycle pulses spaced 20 cycles apart, data 0x01..0x06 -> frames 0x01..0x05 sent with 1-cycle gaps. tx_fifo_full=1 after the 5th push; 0x06 dropped; tx_overflow=1 and stays set.
- Reset asserted 35 cycles into the 0x55 frame -> uart_txd=1 in the same cycle, tx_busy=0, no further frames after release.
- With UART_TX_PARITY_EN defined, data 0x07 -> parity bit 1 after bit 7; frame is 110 cycles. Data 0x03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered UART transmitter; each rising edge of uart_tx_enable sends one 8N1 frame.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit between data and stop.
module uart_tx #(
  parameter logic [31:0] CLK_FREQ        = 32'd50_000_000,
  parameter logic [31:0] BAUD_RATE       = 32'd115_200,
  parameter int          FIFO_DEPTH_LOG2 = 2
) (
  input  logic       clk_50m,
  input  logic       reset,
  input  logic [7:0] uart_tx_data,
  input  logic       uart_tx_enable,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       tx_fifo_full,
  output logic       tx_overflow
);

  localparam logic [31:0] BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int          BCW      = $clog2(BAUD_DIV);
  localparam int          AW       = FIFO_DEPTH_LOG2;
  localparam int          CW       = AW + 1;
  localparam int          DEPTH    = 1 << AW;

  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 32'd1);
  localparam logic [BCW-1:0] BAUD_ONE  = BCW'(32'd1);
  localparam logic [BCW-1:0] BAUD_ZERO = BCW'(32'd0);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(32'd1);
  localparam logic [CW-1:0]  CNT_ZERO  = CW'(32'd0);
  localparam logic [AW-1:0]  PTR_ONE   = AW'(32'd1);
  localparam logic [AW-1:0]  PTR_ZERO  = AW'(32'd0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    ST_PARITY = 3'd4,
`endif
    ST_STOP   = 3'd3
  } state_t;

  logic           r_en_d1;
  logic           r_en_d2;
  logic [7:0]     r_fifo [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_ovf;
  logic           r_full;
  logic           r_busy;
  state_t         r_state;
  logic [7:0]     r_shift;
  logic [2:0]     r_bit_cnt;
  logic [BCW-1:0] r_baud_cnt;
  logic           r_txd;
`ifdef UART_TX_PARITY_EN
  logic           r_parity;
  logic           w_parity_next;
`endif

  logic           w_push;
  logic           w_pop;
  logic           w_accept;
  logic           w_bit_end;
  logic [CW-1:0]  w_count_next;
  state_t         w_state_next;
  logic [7:0]     w_shift_next;
  logic [2:0]     w_bit_next;
  logic [BCW-1:0] w_baud_next;
  logic           w_txd_next;

  assign w_push    = r_en_d1 & ~r_en_d2;
  assign w_bit_end = (r_baud_cnt == BAUD_LAST);

  // Enable edge detector: a push fires once, one cycle after enable is first seen high
  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      r_en_d1 <= 1'b0;
      r_en_d2 <= 1'b0;
    end else begin
      r_en_d1 <= uart_tx_enable;
      r_en_d2 <= r_en_d1;
    end
  end

  // FIFO occupancy: a push into a full FIFO still fits when the same cycle pops
  always_comb begin
    w_accept     = w_push & ((r_count != FULL_CNT) | w_pop);
    w_count_next = r_count;
    case ({w_accept, w_pop})
      2'b10:   w_count_next = r_count + CNT_ONE;
      2'b01:   w_count_next = r_count - CNT_ONE;
      default: w_count_next = r_count;
    endcase
  end

  // FIFO storage; stale entries are never read because count gates every pop
  always_ff @(posedge clk_50m) begin
    if (w_accept) begin
      r_fifo[r_wr_ptr] <= uart_tx_data;
    end
  end

  // FIFO pointers plus registered status flags
  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_count  <= CNT_ZERO;
      r_ovf    <= 1'b0;
      r_full   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_count <= w_count_next;
      r_ovf   <= r_ovf | (w_push & ~w_accept);
      r_full  <= (w_count_next == FULL_CNT);
      r_busy  <= (w_state_next != ST_IDLE) | (w_count_next != CNT_ZERO);
    end
  end

  // Frame sequencer next-state; the line level is derived from the next state so txd stays registered
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_shift_next = r_shift;
    w_bit_next   = r_bit_cnt;
    w_baud_next  = r_baud_cnt + BAUD_ONE;
`ifdef UART_TX_PARITY_EN
    w_parity_next = r_parity;
`endif
    case (r_state)
      ST_IDLE: begin
        w_baud_next = BAUD_ZERO;
        if (r_count != CNT_ZERO) begin
          w_pop        = 1'b1;
          w_shift_next = r_fifo[r_rd_ptr];
          w_bit_next   = 3'd0;
          w_state_next = ST_START;
`ifdef UART_TX_PARITY_EN
          w_parity_next = ^r_fifo[r_rd_ptr];
`endif
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_baud_next  = BAUD_ZERO;
          w_state_next = ST_DATA;
        end else begin
          w_state_next = ST_START;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_baud_next = BAUD_ZERO;
          if (r_bit_cnt == 3'd7) begin
            w_bit_next = 3'd0;
`ifdef UART_TX_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_STOP;
`endif
          end else begin
            w_shift_next = {1'b0, r_shift[7:1]};
            w_bit_next   = r_bit_cnt + 3'd1;
          end
        end else begin
          w_state_next = ST_DATA;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_bit_end) begin
          w_baud_next  = BAUD_ZERO;
          w_state_next = ST_STOP;
        end else begin
          w_state_next = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (w_bit_end) begin
          w_baud_next  = BAUD_ZERO;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_STOP;
        end
      end
      default: begin
        w_baud_next  = BAUD_ZERO;
        w_state_next = ST_IDLE;
      end
    endcase

    case (w_state_next)
      ST_START:  w_txd_next = 1'b0;
      ST_DATA:   w_txd_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_txd_next = w_parity_next;
`endif
      default:   w_txd_next = 1'b1;
    endcase
  end

  // Sequencer and serializer registers; reset forces the line idle immediately
  always_ff @(posedge clk_50m or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_shift    <= 8'd0;
      r_bit_cnt  <= 3'd0;
      r_baud_cnt <= BAUD_ZERO;
      r_txd      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_next;
      r_baud_cnt <= w_baud_next;
      r_txd      <= w_txd_next;
`ifdef UART_TX_PARITY_EN
      r_parity   <= w_parity_next;
`endif
    end
  end

  assign uart_txd     = r_txd;
  assign tx_busy      = r_busy;
  assign tx_fifo_full = r_full;
  assign tx_overflow  = r_ovf;

endmodule
